// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding
// and the identifiers of the two requesting ports.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision: data port has priority, except that the fetch
// port is forced through once the data port has won MAX_DM_STREAK times in a row.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4,
    parameter int STREAK_W      = 3
) (
    input  logic                i_if_req,
    input  logic                i_dm_req,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_grant_if,
    output logic                o_grant_dm
);

    logic w_if_forced;

    assign w_if_forced = i_if_req && (i_streak == STREAK_W'(MAX_DM_STREAK));
    assign o_grant_dm  = i_dm_req && !w_if_forced;
    assign o_grant_if  = i_if_req && !o_grant_dm;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory backend between the instruction-fetch port and
// the data port; one backend transaction outstanding at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

    logic [1:0]          r_state;
    logic [STREAK_W-1:0] r_streak;
    logic                r_dropped;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_grant_if;
    logic                w_grant_dm;
    logic                w_grant_port;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [ADDR_W-1:0]   w_aligned_addr;
    logic [STREAK_W-1:0] w_streak_inc;
    logic                w_busy_req;
    logic                w_unused_addr_lsbs;

    mem_arb_grant #(
        .MAX_DM_STREAK (MAX_DM_STREAK),
        .STREAK_W      (STREAK_W)
    ) u_grant (
        .i_if_req   (if_req),
        .i_dm_req   (dm_req),
        .i_streak   (r_streak),
        .o_grant_if (w_grant_if),
        .o_grant_dm (w_grant_dm)
    );

    assign w_grant_port   = w_grant_dm ? PORT_DM : PORT_IF;
    assign w_sel_addr     = (w_grant_port == PORT_DM) ? dm_addr : if_addr;
    assign w_aligned_addr = {w_sel_addr[ADDR_W-1:2], 2'b00};
    // Byte-lane bits are dropped on purpose; no misalignment detection.
    assign w_unused_addr_lsbs = ^w_sel_addr[1:0];

    assign w_streak_inc = (r_streak == STREAK_W'(MAX_DM_STREAK)) ? r_streak
                                                                  : r_streak + STREAK_W'(1);
    assign w_busy_req   = (r_state == ST_BUSY_DM) ? dm_req : if_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_streak    <= '0;
            r_dropped   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_dm || w_grant_if) begin
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_aligned_addr;
                        r_dropped  <= 1'b0;
                        if (w_grant_dm) begin
                            r_mem_we    <= dm_we;
                            r_mem_wdata <= dm_wdata;
                            r_state     <= ST_BUSY_DM;
                            r_streak    <= if_req ? w_streak_inc : '0;
                        end else begin
                            r_mem_we <= 1'b0;
                            r_state  <= ST_BUSY_IF;
                            r_streak <= '0;
                        end
                    end
                end
                ST_BUSY_IF, ST_BUSY_DM: begin
                    // A requester that lets go mid-transaction forfeits its ack.
                    if (!w_busy_req) begin
                        r_dropped <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (w_busy_req && !r_dropped) begin
                            if (r_state == ST_BUSY_IF) begin
                                r_if_ack   <= 1'b1;
                                r_if_rdata <= mem_rdata;
                            end else begin
                                r_dm_ack   <= 1'b1;
                                r_dm_rdata <= r_mem_we ? '0 : mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_ack    = r_if_ack;
    assign dm_ack    = r_dm_ack;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule
